issue_tracker: RTL and testbench

//  Parametrised in-flight instruction tracker for the issue stage: circular buffer of NR_ENTRIES

---
 rtl/issue_tracker.sv | 176 +++++++++++++++++
 tb/tb_issue_tracker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_tracker.sv
// In-flight instruction tracker: program-order circular buffer with writeback marking, in-order
// multi-port commit and combinational per-operand busy/forward lookup for GPR and FPR files.
module issue_tracker #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_WB_PORTS     = 4,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int REG_ADDR_W      = 5,
    parameter int DATA_W          = 64,
    localparam int IDW            = $clog2(NR_ENTRIES),
    localparam int CW             = $clog2(NR_ENTRIES + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                issue_valid_i,
    input  logic [REG_ADDR_W-1:0]               issue_rd_i,
    input  logic                                issue_fpr_i,
    output logic                                issue_ready_o,
    output logic [IDW-1:0]                      issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]              wb_valid_i,
    input  logic [NR_WB_PORTS*IDW-1:0]          wb_trans_id_i,
    input  logic [NR_WB_PORTS*DATA_W-1:0]       wb_data_i,
    input  logic [2*REG_ADDR_W-1:0]             rs_addr_i,
    input  logic [1:0]                          rs_fpr_i,
    output logic [1:0]                          rs_busy_o,
    output logic [1:0]                          rs_fwd_valid_o,
    output logic [2*DATA_W-1:0]                 rs_data_o,
    output logic [NR_COMMIT_PORTS-1:0]          commit_valid_o,
    output logic [NR_COMMIT_PORTS*IDW-1:0]      commit_trans_id_o,
    output logic [NR_COMMIT_PORTS*REG_ADDR_W-1:0] commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0]          commit_fpr_o,
    output logic [NR_COMMIT_PORTS*DATA_W-1:0]   commit_data_o,
    input  logic [NR_COMMIT_PORTS-1:0]          commit_ack_i,
    output logic                                full_o,
    output logic                                empty_o,
    output logic [CW-1:0]                       count_o
);

    logic [NR_ENTRIES-1:0] valid_q, valid_d, done_q, done_d, fpr_q, fpr_d;
    logic [REG_ADDR_W-1:0] rd_q   [NR_ENTRIES];
    logic [REG_ADDR_W-1:0] rd_d   [NR_ENTRIES];
    logic [DATA_W-1:0]     data_q [NR_ENTRIES];
    logic [DATA_W-1:0]     data_d [NR_ENTRIES];
    logic [IDW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [CW-1:0]         retired;
    logic [NR_ENTRIES-1:0] retire_mask;
    logic                  issue_fire;
    logic                  prefix, stop;
    logic [IDW-1:0]        cidx, widx, lidx;
    logic [1:0]            hit;
    logic [IDW-1:0]        hid [2];

    assign full_o           = (count_q == CW'(NR_ENTRIES));
    assign empty_o          = (count_q == '0);
    assign issue_ready_o    = !full_o;
    assign issue_trans_id_o = wr_ptr_q;
    assign count_o          = count_q;
    assign issue_fire       = issue_valid_i && issue_ready_o;

    // Commit window: valid is a prefix; retirement stops at the first un-acked port.
    always_comb begin
        commit_valid_o    = '0;
        commit_trans_id_o = '0;
        commit_rd_o       = '0;
        commit_fpr_o      = '0;
        commit_data_o     = '0;
        retired           = '0;
        retire_mask       = '0;
        prefix            = 1'b1;
        stop              = 1'b0;
        cidx              = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            cidx   = rd_ptr_q + IDW'(k);
            prefix = prefix && valid_q[cidx] && done_q[cidx];
            commit_valid_o[k]                       = prefix;
            commit_trans_id_o[k*IDW +: IDW]         = cidx;
            commit_rd_o[k*REG_ADDR_W +: REG_ADDR_W] = rd_q[cidx];
            commit_fpr_o[k]                         = fpr_q[cidx];
            commit_data_o[k*DATA_W +: DATA_W]       = prefix ? data_q[cidx] : '0;
            if (!stop && prefix && commit_ack_i[k]) begin
                retired           = retired + CW'(1);
                retire_mask[cidx] = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Youngest matching producer wins: later slots in age order overwrite earlier hits.
    always_comb begin
        rs_busy_o      = '0;
        rs_fwd_valid_o = '0;
        rs_data_o      = '0;
        hit            = '0;
        lidx           = '0;
        for (int i = 0; i < 2; i++) begin
            hid[i] = '0;
            for (int k = 0; k < NR_ENTRIES; k++) begin
                lidx = rd_ptr_q + IDW'(k);
                if (valid_q[lidx] && fpr_q[lidx] == rs_fpr_i[i] &&
                    rd_q[lidx] == rs_addr_i[i*REG_ADDR_W +: REG_ADDR_W]) begin
                    hit[i] = 1'b1;
                    hid[i] = lidx;
                end
            end
            if (!rs_fpr_i[i] && rs_addr_i[i*REG_ADDR_W +: REG_ADDR_W] == '0) hit[i] = 1'b0;
            if (hit[i]) begin
                if (done_q[hid[i]]) begin
                    rs_fwd_valid_o[i]             = 1'b1;
                    rs_data_o[i*DATA_W +: DATA_W] = data_q[hid[i]];
                end else begin
                    rs_busy_o[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        fpr_d    = fpr_q;
        rd_d     = rd_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + IDW'(retired);
        count_d  = count_q + CW'(issue_fire) - retired;
        widx     = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            widx = wb_trans_id_i[p*IDW +: IDW];
            if (wb_valid_i[p] && valid_q[widx]) begin
                done_d[widx] = 1'b1;
                data_d[widx] = wb_data_i[p*DATA_W +: DATA_W];
            end
        end
        valid_d = valid_d & ~retire_mask;
        if (issue_fire) begin
            valid_d[wr_ptr_q] = 1'b1;
            done_d[wr_ptr_q]  = 1'b0;
            fpr_d[wr_ptr_q]   = issue_fpr_i;
            rd_d[wr_ptr_q]    = issue_rd_i;
            wr_ptr_d          = wr_ptr_q + IDW'(1);
        end
        if (flush_i) begin
            valid_d  = '0;
            done_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            done_q   <= '0;
            fpr_q    <= '0;
            rd_q     <= '{default: '0};
            data_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            fpr_q    <= fpr_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_tracker.sv
// Directed bench for issue_tracker with hand-computed expectations.
module tb_issue_tracker;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         issue_valid_i;
    logic [4:0]   issue_rd_i;
    logic         issue_fpr_i;
    logic         issue_ready_o;
    logic [2:0]   issue_trans_id_o;
    logic [3:0]   wb_valid_i;
    logic [11:0]  wb_trans_id_i;
    logic [255:0] wb_data_i;
    logic [9:0]   rs_addr_i;
    logic [1:0]   rs_fpr_i;
    logic [1:0]   rs_busy_o;
    logic [1:0]   rs_fwd_valid_o;
    logic [127:0] rs_data_o;
    logic [1:0]   commit_valid_o;
    logic [5:0]   commit_trans_id_o;
    logic [9:0]   commit_rd_o;
    logic [1:0]   commit_fpr_o;
    logic [127:0] commit_data_o;
    logic [1:0]   commit_ack_i;
    logic         full_o;
    logic         empty_o;
    logic [3:0]   count_o;

    int n_chk  = 0;
    int n_pass = 0;

    issue_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_fpr_i(issue_fpr_i),
        .issue_ready_o(issue_ready_o), .issue_trans_id_o(issue_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i), .wb_data_i(wb_data_i),
        .rs_addr_i(rs_addr_i), .rs_fpr_i(rs_fpr_i), .rs_busy_o(rs_busy_o),
        .rs_fwd_valid_o(rs_fwd_valid_o), .rs_data_o(rs_data_o),
        .commit_valid_o(commit_valid_o), .commit_trans_id_o(commit_trans_id_o),
        .commit_rd_o(commit_rd_o), .commit_fpr_o(commit_fpr_o), .commit_data_o(commit_data_o),
        .commit_ack_i(commit_ack_i), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic fpr);
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
        issue_fpr_i   = fpr;
        cyc();
        issue_valid_i = 1'b0;
        #1;
    endtask

    task automatic set_wb(input int p, input logic [2:0] id, input logic [63:0] d);
        wb_valid_i[p]          = 1'b1;
        wb_trans_id_i[p*3 +: 3] = id;
        wb_data_i[p*64 +: 64]   = d;
    endtask

    task automatic end_cycle();
        cyc();
        wb_valid_i    = '0;
        commit_ack_i  = '0;
        issue_valid_i = 1'b0;
        flush_i       = 1'b0;
        #1;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        end_cycle();
    endtask

    task automatic query(input logic [4:0] a1, input logic f1, input logic [4:0] a2, input logic f2);
        rs_addr_i = {a2, a1};
        rs_fpr_i  = {f2, f1};
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_rd_i = '0; issue_fpr_i = 1'b0;
        wb_valid_i = '0; wb_trans_id_i = '0; wb_data_i = '0; rs_addr_i = '0; rs_fpr_i = '0;
        commit_ack_i = '0;
        cyc(); cyc();
        rst_i = 1'b0;
        #1;

        // Reset state
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ready", issue_ready_o, 1);
        chk("rst_tid", issue_trans_id_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_cvalid", commit_valid_o, 0);
        chk("rst_busy", rs_busy_o, 0);
        chk("rst_fwd", rs_fwd_valid_o, 0);
        chk("rst_rsdata", rs_data_o[63:0], 0);
        chk("rst_cdata", commit_data_o[63:0], 0);

        // Fill: rd=1..8 receive ids 0..7
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_tid%0d", i), issue_trans_id_o, i);
            do_issue(5'(i + 1), 1'b0);
        end
        chk("fill_full", full_o, 1);
        chk("fill_ready", issue_ready_o, 0);
        chk("fill_count", count_o, 8);
        query(5'd3, 1'b0, 5'd8, 1'b1);
        chk("fill_busy", rs_busy_o, 2'b01);

        // Full tracker: ack head and attempt issue in the same cycle
        set_wb(0, 3'd0, 64'h11);
        end_cycle();
        chk("full_cvalid", commit_valid_o, 2'b01);
        commit_ack_i = 2'b01;
        issue_valid_i = 1'b1; issue_rd_i = 5'd9; issue_fpr_i = 1'b0;
        end_cycle();
        chk("full_refuse_count", count_o, 7);
        chk("full_refuse_tid", issue_trans_id_o, 0);
        do_issue(5'd9, 1'b0);
        chk("wrap_tid", issue_trans_id_o, 1);
        chk("wrap_count", count_o, 8);
        query(5'd9, 1'b0, 5'd0, 1'b0);
        chk("wrap_busy", rs_busy_o, 2'b01);

        // Youngest producer selection and forwarding
        do_flush();
        do_issue(5'd5, 1'b0);
        do_issue(5'd5, 1'b0);
        set_wb(0, 3'd0, 64'hAA);
        end_cycle();
        query(5'd5, 1'b0, 5'd5, 1'b1);
        chk("young_busy", rs_busy_o, 2'b01);
        chk("young_fwd", rs_fwd_valid_o, 2'b00);
        set_wb(1, 3'd1, 64'hCC);
        set_wb(3, 3'd1, 64'hBB);
        #1;
        chk("nobypass_busy", rs_busy_o, 2'b01);
        end_cycle();
        chk("fwd_valid", rs_fwd_valid_o, 2'b01);
        chk("fwd_busy", rs_busy_o, 2'b00);
        chk("fwd_data", rs_data_o[63:0], 64'hBB);
        chk("fwd_data_rs2", rs_data_o[127:64], 0);

        // In-order commit prefix and ack handling
        do_flush();
        do_issue(5'd10, 1'b0);
        do_issue(5'd11, 1'b1);
        do_issue(5'd12, 1'b0);
        set_wb(0, 3'd1, 64'h71);
        set_wb(2, 3'd2, 64'h72);
        end_cycle();
        chk("commit_none", commit_valid_o, 2'b00);
        set_wb(1, 3'd0, 64'h70);
        end_cycle();
        chk("commit_both", commit_valid_o, 2'b11);
        chk("commit_tids", commit_trans_id_o, 6'o10);
        chk("commit_rds", commit_rd_o, {5'd11, 5'd10});
        chk("commit_fprs", commit_fpr_o, 2'b10);
        chk("commit_data0", commit_data_o[63:0], 64'h70);
        chk("commit_data1", commit_data_o[127:64], 64'h71);
        commit_ack_i = 2'b10;
        end_cycle();
        chk("ack10_count", count_o, 3);
        commit_ack_i = 2'b11;
        end_cycle();
        chk("ack11_count", count_o, 1);
        chk("ack11_cvalid", commit_valid_o, 2'b01);
        chk("ack11_tid0", commit_trans_id_o[2:0], 2);
        set_wb(0, 3'd5, 64'h55);
        end_cycle();
        chk("wb_invalid_slot_count", count_o, 1);

        // x0 never busy; f0 is a real register
        do_flush();
        do_issue(5'd0, 1'b0);
        do_issue(5'd0, 1'b1);
        query(5'd0, 1'b0, 5'd0, 1'b1);
        chk("x0_f0_busy", rs_busy_o, 2'b10);

        // Flush with concurrent issue and writeback
        do_flush();
        for (int i = 0; i < 5; i++) do_issue(5'(i + 20), 1'b0);
        chk("preflush_count", count_o, 5);
        flush_i = 1'b1;
        issue_valid_i = 1'b1; issue_rd_i = 5'd25;
        set_wb(0, 3'd0, 64'h99);
        end_cycle();
        query(5'd20, 1'b0, 5'd25, 1'b0);
        chk("flush_empty", empty_o, 1);
        chk("flush_count", count_o, 0);
        chk("flush_tid", issue_trans_id_o, 0);
        chk("flush_busy", rs_busy_o | rs_fwd_valid_o, 0);
        chk("flush_cvalid", commit_valid_o, 0);

        // Asynchronous reset in the middle of traffic
        do_issue(5'd7, 1'b0);
        do_issue(5'd8, 1'b0);
        set_wb(0, 3'd0, 64'h1234);
        end_cycle();
        query(5'd7, 1'b0, 5'd8, 1'b0);
        chk("pre_rst_fwd", rs_fwd_valid_o, 2'b01);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_count", count_o, 0);
        chk("arst_empty", empty_o, 1);
        chk("arst_ready", issue_ready_o, 1);
        chk("arst_tid", issue_trans_id_o, 0);
        chk("arst_rs", {rs_busy_o, rs_fwd_valid_o}, 0);
        chk("arst_rsdata", rs_data_o[63:0], 0);
        chk("arst_cvalid", commit_valid_o, 0);
        chk("arst_cdata", commit_data_o[63:0], 0);
        cyc();
        rst_i = 1'b0;
        #1;
        chk("post_rst_empty", empty_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
